axis_grant_mux: RTL

AXIS_GRANT_MUX -- requirements
Module: axis_grant_mux

---
 rtl/axis_grant_mux.sv | 131 +++++++++++++
 1 files changed

// File: rtl/axis_grant_mux.sv
// Merges PORTS AXI-Stream inputs onto one output, port chosen by an external acknowledge-mode arbiter.
// Latency: one cycle from accepted input beat to m_tvalid; two-entry skid buffer, no bubbles.
// Backpressure: s_tready of the granted port drops only when both buffer entries are occupied.
module axis_grant_mux #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    localparam int SEL_W     = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [PORTS-1:0]            s_tvalid,
    input  logic [PORTS-1:0]            s_tlast,
    output logic [PORTS-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]       m_tdata,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    input  logic                        m_tready,
    output logic [PORTS-1:0]            arb_request,
    output logic [PORTS-1:0]            arb_acknowledge,
    input  logic [PORTS-1:0]            arb_grant,
    input  logic                        arb_grant_valid,
    input  logic [SEL_W-1:0]            arb_grant_encoded,
    output logic                        err_grant_switch
);

    typedef enum logic {IDLE, PKT} state_t;

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        cur_port;
    logic [1:0]              count_q;
    logic                    buf_full;
    logic [DATA_WIDTH-1:0]   skid_data_q;
    logic                    skid_last_q;
    logic [PORTS-1:0]        enc_onehot;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_last;
    logic                    port_ok;
    logic                    in_fire;
    logic                    pop;
    logic                    err_cond;

    assign arb_request = s_tvalid;
    assign buf_full    = (count_q == 2'd2);
    assign m_tvalid    = (count_q != 2'd0);
    assign pop         = m_tvalid & m_tready;

    // The encoded grant is the only port selector; the one-hot vector is
    // cross-checked against it for protocol errors.
    always_comb begin
        enc_onehot = '0;
        sel_data   = '0;
        sel_last   = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            enc_onehot[i] = (arb_grant_encoded == SEL_W'(i));
            if (enc_onehot[i]) begin
                sel_data = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last = s_tlast[i];
            end
        end
        port_ok         = (state_q == IDLE) || (arb_grant_encoded == cur_port);
        s_tready        = arb_grant & enc_onehot & {PORTS{arb_grant_valid & ~buf_full & port_ok}};
        in_fire         = |(s_tready & s_tvalid);
        arb_acknowledge = arb_grant & s_tvalid & s_tready & s_tlast;
        err_cond        = ((state_q == PKT) && (!arb_grant_valid || (arb_grant_encoded != cur_port)))
                        || (|(arb_grant & ~enc_onehot));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire && !sel_last) state_d = PKT;
            PKT:     if (in_fire && sel_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            cur_port         <= '0;
            err_grant_switch <= 1'b0;
        end else begin
            state_q          <= state_d;
            err_grant_switch <= err_grant_switch | err_cond;
            if (state_q == IDLE && in_fire && !sel_last)
                cur_port <= arb_grant_encoded;
        end
    end

    // Main register drives the output; the skid entry only fills when a beat
    // arrives while the main register is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= 2'd0;
            m_tdata     <= '0;
            m_tlast     <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
        end else begin
            case ({in_fire, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        m_tdata <= sel_data;
                        m_tlast <= sel_last;
                        count_q <= 2'd1;
                    end else begin
                        skid_data_q <= sel_data;
                        skid_last_q <= sel_last;
                        count_q     <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        m_tdata <= skid_data_q;
                        m_tlast <= skid_last_q;
                        count_q <= 2'd1;
                    end else begin
                        count_q <= 2'd0;
                    end
                end
                2'b11: begin
                    m_tdata <= sel_data;
                    m_tlast <= sel_last;
                end
                default: ;
            endcase
        end
    end

endmodule
